// File: rtl/ccc_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ccc_cfg_pkg
// Purpose  : Shared types and APB widths for the CCC configuration master.
// Revision : 1.0 - initial release
// ============================================================================
package ccc_cfg_pkg;

    localparam int APB_AW = 6;
    localparam int APB_DW = 8;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_RELOCK = 2'b10,
        OP_RSVD   = 2'b11
    } ccc_op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_ACCESS    = 3'd2,
        ST_VSETUP    = 3'd3,
        ST_VACCESS   = 3'd4,
        ST_RST_HOLD  = 3'd5,
        ST_LOCK_WAIT = 3'd6,
        ST_RESP      = 3'd7
    } ccc_state_e;

endpackage
`default_nettype wire

// File: rtl/ccc_lock_sync.sv
`default_nettype none
// ============================================================================
// Module   : ccc_lock_sync
// Purpose  : Two-flop synchronizer bringing the raw CCC LOCK into PCLK.
// Revision : 1.0 - initial release
// ============================================================================
module ccc_lock_sync
    import ccc_cfg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_lock,
    output logic o_locked
);

    logic r_meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta   <= 1'b0;
            o_locked <= 1'b0;
        end else begin
            r_meta   <= i_lock;
            o_locked <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ccc_apb_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : ccc_apb_cfg_master
// Purpose  : APB initiator for the CCC/PLL dynamic-configuration port with
//            register write/read and PLL relock. Define CCC_CFG_READBACK_EN
//            to verify every write with a readback of the same address.
// Revision : 1.0 - initial release
// ============================================================================
module ccc_apb_cfg_master
    import ccc_cfg_pkg::*;
#(
    parameter int ARST_CYCLES  = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [APB_AW-1:0] cmd_addr,
    input  logic [APB_DW-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [APB_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_AW-1:0] PADDR,
    output logic [APB_DW-1:0] PWDATA,
    input  logic [APB_DW-1:0] PRDATA,
    output logic              PLL_ARST_N,
    input  logic              LOCK,
    output logic              locked
);

    localparam int c_ARST_W = (ARST_CYCLES > 1) ? $clog2(ARST_CYCLES) : 1;
    localparam int c_LOCK_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [c_ARST_W-1:0] c_ARST_LAST = c_ARST_W'(ARST_CYCLES - 1);
    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_LOCK_W-1:0] c_LOCK_IGN  = c_LOCK_W'(2);
    localparam logic [c_LOCK_W-1:0] c_LOCK_MAX  = '1;

    ccc_state_e          r_state;
    logic [c_ARST_W-1:0] r_arst_cnt;
    logic [c_LOCK_W-1:0] r_lock_cnt;

    ccc_lock_sync u_lock_sync (
        .clk      (PCLK),
        .rst      (PRESET),
        .i_lock   (LOCK),
        .o_locked (locked)
    );

    assign cmd_ready = (r_state == ST_IDLE);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state    <= ST_IDLE;
            r_arst_cnt <= '0;
            r_lock_cnt <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PLL_ARST_N <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (ccc_op_e'(cmd_op))
                            OP_WRITE: begin
                                PSEL    <= 1'b1;
                                PENABLE <= 1'b0;
                                PWRITE  <= 1'b1;
                                PADDR   <= cmd_addr;
                                PWDATA  <= cmd_wdata;
                                r_state <= ST_SETUP;
                            end
                            OP_READ: begin
                                PSEL    <= 1'b1;
                                PENABLE <= 1'b0;
                                PWRITE  <= 1'b0;
                                PADDR   <= cmd_addr;
                                r_state <= ST_SETUP;
                            end
                            OP_RELOCK: begin
                                PLL_ARST_N <= 1'b0;
                                r_arst_cnt <= '0;
                                r_state    <= ST_RST_HOLD;
                            end
                            default: begin
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_rdata <= '0;
                                r_state   <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    PENABLE <= 1'b0;
`ifdef CCC_CFG_READBACK_EN
                    if (PWRITE) begin
                        // PSEL stays high: the readback setup phase follows directly
                        PWRITE  <= 1'b0;
                        r_state <= ST_VSETUP;
                    end else begin
                        PSEL      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= PRDATA;
                        r_state   <= ST_RESP;
                    end
`else
                    PSEL      <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= PWRITE ? '0 : PRDATA;
                    r_state   <= ST_RESP;
`endif
                end
`ifdef CCC_CFG_READBACK_EN
                ST_VSETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= ST_VACCESS;
                end
                ST_VACCESS: begin
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= (PRDATA != PWDATA);
                    rsp_rdata <= PRDATA;
                    r_state   <= ST_RESP;
                end
`endif
                ST_RST_HOLD: begin
                    if (r_arst_cnt == c_ARST_LAST) begin
                        PLL_ARST_N <= 1'b1;
                        r_lock_cnt <= '0;
                        r_state    <= ST_LOCK_WAIT;
                    end else begin
                        r_arst_cnt <= r_arst_cnt + 1'b1;
                    end
                end
                ST_LOCK_WAIT: begin
                    // The first two cycles may still see a lock from before the reset
                    if ((r_lock_cnt >= c_LOCK_IGN) && locked) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        r_state   <= ST_RESP;
                    end else if (r_lock_cnt == c_LOCK_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        r_state   <= ST_RESP;
                    end else if (r_lock_cnt != c_LOCK_MAX) begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_err <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccc_apb_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccc_apb_cfg_master
// Purpose  : Scoreboard bench for ccc_apb_cfg_master (APB, relock, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccc_apb_cfg_master;

    localparam int c_ARST     = 16;
    localparam int c_TMO      = 64;
    localparam int c_LOCK_DLY = 10;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [5:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL, PENABLE, PWRITE;
    logic [5:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PLL_ARST_N;
    logic       LOCK = 1'b0;
    logic       locked;

    typedef struct {
        int         cyc;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb[$];
    exp_t       m_exp;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         lock_mode = 1;
    int         lock_cnt = 0;
    int         arst_low = 0;
    logic [7:0] rd_val = '0;

    ccc_apb_cfg_master #(
        .ARST_CYCLES  (c_ARST),
        .LOCK_TIMEOUT (c_TMO)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PLL_ARST_N (PLL_ARST_N),
        .LOCK       (LOCK),
        .locked     (locked)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    assign PRDATA = rd_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // PLL model: lock drops under reset, mode picks stuck-low, stuck-high or delayed lock
    always @(negedge PCLK) begin
        if (PLL_ARST_N !== 1'b1) lock_cnt = 0;
        else if (lock_cnt < 1000) lock_cnt = lock_cnt + 1;
        case (lock_mode)
            0:       LOCK = 1'b0;
            1:       LOCK = 1'b1;
            default: LOCK = (lock_cnt >= c_LOCK_DLY);
        endcase
        if (PLL_ARST_N === 1'b0) arst_low = arst_low + 1;
    end

    always @(negedge PCLK) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                m_exp = sb.pop_front();
                check("rsp_cycle", cyc, m_exp.cyc);
                check("rsp_err", rsp_err, m_exp.err);
                check("rsp_rdata", rsp_rdata, m_exp.rdata);
            end
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] addr, input logic [7:0] wdata,
                           input bit push, input int lat, input logic exp_err,
                           input logic [7:0] exp_rdata, output int t0);
        int guard;
        guard = 0;
        @(negedge PCLK);
        while (cmd_ready !== 1'b1 && guard < 100) begin
            @(negedge PCLK);
            guard++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(posedge PCLK);
        #1;
        t0 = cyc - 1;
        cmd_valid = 1'b0;
        if (push) sb.push_back('{t0 + lat, exp_err, exp_rdata});
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge PCLK);
        check("rsp_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [7:0] data);
        int t0;
`ifdef CCC_CFG_READBACK_EN
        run_cmd(2'b00, addr, data, 1'b1, 5, (rd_val != data), rd_val, t0);
`else
        run_cmd(2'b00, addr, data, 1'b1, 3, 1'b0, 8'h00, t0);
`endif
        @(negedge PCLK);
        check("wr_setup_ctl", {PSEL, PENABLE, PWRITE}, 3'b101);
        check("wr_setup_addr", PADDR, addr);
        check("wr_setup_data", PWDATA, data);
        @(negedge PCLK);
        check("wr_access_ctl", {PSEL, PENABLE, PWRITE}, 3'b111);
`ifdef CCC_CFG_READBACK_EN
        @(negedge PCLK);
        check("rb_setup_ctl", {PSEL, PENABLE, PWRITE}, 3'b100);
        check("rb_setup_addr", PADDR, addr);
        @(negedge PCLK);
        check("rb_access_ctl", {PSEL, PENABLE, PWRITE}, 3'b110);
`endif
        wait_rsp();
        check("wr_idle_psel", {PSEL, PENABLE}, 2'b00);
    endtask

    task automatic do_read(input logic [5:0] addr, input logic [7:0] data);
        int t0;
        rd_val = data;
        run_cmd(2'b01, addr, 8'h00, 1'b1, 3, 1'b0, data, t0);
        @(negedge PCLK);
        check("rd_setup_ctl", {PSEL, PENABLE, PWRITE}, 3'b100);
        check("rd_setup_addr", PADDR, addr);
        @(negedge PCLK);
        check("rd_access_ctl", {PSEL, PENABLE, PWRITE}, 3'b110);
        wait_rsp();
    endtask

    task automatic do_relock(input int mode, input int lat, input logic exp_err);
        int t0;
        lock_mode = mode;
        @(negedge PCLK);
        arst_low = 0;
        run_cmd(2'b10, 6'h00, 8'h00, 1'b1, lat, exp_err, 8'h00, t0);
        wait_rsp();
        check("relock_arst_low_cycles", arst_low, c_ARST);
        check("relock_arst_n_after", PLL_ARST_N, 1);
    endtask

    initial begin
        int t0;
        #2 PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        check("rst_apb_ctl", {PSEL, PENABLE, PWRITE}, 3'b000);
        check("rst_paddr", PADDR, 6'h00);
        check("rst_pwdata", PWDATA, 8'h00);
        check("rst_arst_n", PLL_ARST_N, 1);
        check("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
        check("rst_rdata", rsp_rdata, 8'h00);
        check("rst_locked", locked, 0);
        check("rst_ready", cmd_ready, 1);
        PRESET = 1'b0;

        rd_val = 8'hA3;
        do_write(6'h05, 8'hA3);

        // cmd_valid held high across the read: second accept on the first IDLE edge
        rd_val = 8'h5C;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_addr  = 6'h12;
        @(posedge PCLK);
        #1;
        t0 = cyc - 1;
        sb.push_back('{t0 + 3, 1'b0, 8'h5C});
        sb.push_back('{t0 + 7, 1'b0, 8'h5C});
        for (int k = 1; k <= 4; k++) begin
            @(negedge PCLK);
            check("b2b_ready", cmd_ready, (k == 4) ? 1 : 0);
        end
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        wait_rsp();

        rd_val = 8'h3D;
        do_write(6'h3F, 8'h3C);

        run_cmd(2'b11, 6'h2A, 8'hFF, 1'b1, 1, 1'b1, 8'h00, t0);
        @(negedge PCLK);
        check("rsvd_no_psel", PSEL, 0);
        check("rsvd_paddr_hold", PADDR, 6'h3F);
        wait_rsp();

        do_read(6'h21, 8'h96);

        do_relock(1, c_ARST + 4, 1'b0);
        do_relock(2, c_ARST + c_LOCK_DLY + 3, 1'b0);
        check("relock_locked", locked, 1);
        do_relock(0, c_ARST + c_TMO + 1, 1'b1);

        lock_mode = 0;
        run_cmd(2'b10, 6'h00, 8'h00, 1'b0, 0, 1'b0, 8'h00, t0);
        repeat (4) @(negedge PCLK);
        check("midrst_arst_low", PLL_ARST_N, 0);
        PRESET = 1'b1;
        #1;
        check("midrst_arst_n", PLL_ARST_N, 1);
        check("midrst_psel", PSEL, 0);
        check("midrst_rsp", rsp_valid, 0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("midrst_ready", cmd_ready, 1);
        repeat (30) @(negedge PCLK);
        check("midrst_no_rsp", sb.size(), 0);

        rd_val = 8'h5A;
        do_write(6'h00, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
